// File: rtl/sisc_pkg.sv
// Shared definitions for the unified-memory front end: default bus widths,
// read-owner tags and arbitration state encoding.
package sisc_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [0:0] DATA_PRI  = 1'b0;
    localparam logic [0:0] FETCH_PRI = 1'b1;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

    function automatic rd_tag_t make_tag(input logic vld, input logic is_data);
        rd_tag_t t;
        t.vld = vld;
        t.own = is_data ? OWN_DATA : OWN_FETCH;
        return t;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side and memory-side signals of the arbiter, grouped so the
// arbiter sees the slave view and the surrounding system the master view.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rd_tag_pipe.sv
// Fixed-latency read tag pipeline: each cycle shifts in a {valid, owner} tag
// so the tag leaves the head exactly when the memory presents its read data.
module rd_tag_pipe
    import sisc_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push_tag,
    output rd_tag_t head_tag,
    output logic    busy
);

    rd_tag_t tag_p [RD_LAT];

    // Stage boundary: tag_p[i] holds the tag of the access granted i+1 cycles ago
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign head_tag = tag_p[RD_LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            busy = busy | tag_p[i].vld;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter (fetch vs data) in front of a single-port memory,
// with bounded data bursts and owner-tagged fixed-latency read return.
module mem_arb
    import sisc_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int RD_LAT       = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic     CLK,
    input  logic     RST_F,
    mem_arb_if.slave bus,
    output logic     busy
);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] run_cnt;
    logic [3:0] run_nxt;
    logic       f_gnt_c;
    logic       d_gnt_c;
    logic       d_wr_c;
    logic       f_rv;
    logic       d_rv;
    rd_tag_t    push_tag;
    rd_tag_t    head_tag;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        f_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if (!RST_F) begin
            if (bus.f_req && (!bus.d_req || state == FETCH_PRI)) begin
                f_gnt_c = 1'b1;
            end else if (bus.d_req) begin
                d_gnt_c = 1'b1;
            end
        end
    end

    // The run only counts data grants that actually kept a waiting fetch out
    always_comb begin
        run_nxt = run_cnt;
        if (!bus.f_req || f_gnt_c) begin
            run_nxt = '0;
        end else if (d_gnt_c) begin
            run_nxt = sat_inc(run_cnt);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DATA_PRI:  if (run_nxt == 4'(MAX_DATA_RUN)) state_nxt = FETCH_PRI;
            FETCH_PRI: if (f_gnt_c || !bus.f_req)       state_nxt = DATA_PRI;
            default:   state_nxt = DATA_PRI;
        endcase
    end

    // Stage boundary: arbitration state
    always_ff @(posedge CLK) begin
        if (RST_F) begin
            state   <= DATA_PRI;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
        end
    end

    assign d_wr_c        = d_gnt_c & bus.d_we;
    assign bus.f_gnt     = f_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = f_gnt_c | d_gnt_c;
    assign bus.mem_we    = d_wr_c;
    assign bus.mem_addr  = f_gnt_c ? bus.f_addr : (d_gnt_c ? bus.d_addr : '0);
    assign bus.mem_wdata = d_wr_c ? bus.d_wdata : '0;

    assign push_tag = make_tag(f_gnt_c | (d_gnt_c & ~bus.d_we), d_gnt_c);

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk      (CLK),
        .rst      (RST_F),
        .push_tag (push_tag),
        .head_tag (head_tag),
        .busy     (busy)
    );

    // Stage boundary: read return, RD_LAT cycles after the grant
    assign f_rv         = head_tag.vld && (head_tag.own == OWN_FETCH);
    assign d_rv         = head_tag.vld && (head_tag.own == OWN_DATA);
    assign bus.f_rvalid = f_rv;
    assign bus.d_rvalid = d_rv;
    assign bus.f_rdata  = f_rv ? bus.mem_rdata : '0;
    assign bus.d_rdata  = d_rv ? bus.mem_rdata : '0;

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter for a single-port unified memory shared by two requesters: instruction fetch (driven from pc_out) and data load/store (driven by ctrl).
- Issues at most one memory access per cycle.
- Tracks in-flight reads through a fixed-latency tag pipeline and returns each read's data to the requester that issued it.
- Sits between pc/ctrl and the memory macro and replaces the direct PC-to-im read path.

Parameters:
AW, 16, address width
DW, 32, data width
RD_LAT, 1, memory read latency in cycles, legal 1..4; mem_rdata is valid RD_LAT cycles after mem_en with mem_we=0
MAX_DATA_RUN, 4, maximum consecutive data grants while fetch is pending; legal 1..15

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_F  in  1  synchronous reset, active-high (1 = reset)
f_req  in  1  fetch request (read only)
f_addr  in  AW  fetch address
f_gnt  out  1  fetch accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  DW  fetch read data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
d_rdata  out  DW  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  at least one read is in flight

Behaviour:
- Handshake: a requester holds req, addr, we and wdata stable until it sees gnt. gnt is combinational in the same cycle, and the transfer is accepted on that edge. At most one of f_gnt/d_gnt is high per cycle.
- Memory drive: mem_en = f_gnt | d_gnt. mem_addr, mem_we and mem_wdata are muxed combinationally from the winner. mem_we=0 on fetch grants. mem_wdata=0 when no data write is granted.
- Arbitration FSM, two states:
  - DATA_PRI (reset state): d_req wins.
  - FETCH_PRI: f_req wins.
- Run counter:
  - run_cnt (4 bits) increments on each d_gnt issued while f_req=1.
  - It clears on any f_gnt, and also when f_req=0.
- Transitions:
  - DATA_PRI -> FETCH_PRI on the edge where run_cnt reaches MAX_DATA_RUN.
  - FETCH_PRI -> DATA_PRI on the next f_gnt, or immediately if f_req=0.
- Single requester: always granted, in either state.
- Writes:
  - Complete at grant and produce no rvalid.
  - A read to the same address granted in a later cycle returns the new value (memory ordering only; the arbiter does not forward).
- Read tracking:
  - Each read grant pushes tag {valid, owner} into an RD_LAT-deep shift register; a non-read cycle pushes valid=0.
  - At the pipeline output, if valid: owner=fetch asserts f_rvalid, owner=data asserts d_rvalid, for exactly 1 cycle.
  - f_rdata and d_rdata both pass mem_rdata through. Each is held at 0 when its rvalid=0.
- Latency: a read granted in cycle N gives rvalid in cycle N+RD_LAT.
  - Back-to-back reads are fully pipelined, one per cycle, returned in grant order.
- busy = OR of valid bits across the tag pipeline.
- Reset values: f_gnt=d_gnt=0, f_rvalid=d_rvalid=0, rdata=0, mem_en=mem_we=0, mem_addr=0, busy=0, FSM=DATA_PRI, run_cnt=0, tag pipeline cleared.
  - While RST_F=1, all grants are forced to 0 regardless of req.
- Reset mid-operation: in-flight reads are discarded; no rvalid appears after reset deasserts for reads granted before it.
- Simultaneous req with run_cnt below limit: data wins. Fetch is serviced within MAX_DATA_RUN+1 cycles under continuous d_req.
- Request dropped without gnt: illegal, but the arbiter must not deadlock; the FSM recomputes each cycle.

Decomposition:
- Shared package sisc_pkg:
  - AW/DW defaults
  - owner encoding (OWN_FETCH=0, OWN_DATA=1)
  - FSM state encoding (DATA_PRI=0, FETCH_PRI=1)
- One natural sub-module: rd_tag_pipe, the RD_LAT-deep {valid, owner} shift register with synchronous clear. It outputs the head tag and busy.
- Arbitration FSM and muxing stay in mem_arb.

Test Plan:
- Reset: hold RST_F=1 for 3 cycles with f_req=d_req=1 -> f_gnt=d_gnt=mem_en=0, busy=0; after release, first grant goes to data (d_gnt=1).
- Fetch only: RD_LAT=1, f_req=1 with addr 0x0000..0x0003 for 4 cycles, memory returns addr+0x100 -> f_gnt every cycle; f_rvalid cycles 2..5 with f_rdata=0x100..0x103; d_rvalid never asserts.
- Write then read: d_we=1, d_addr=0x0010, d_wdata=0xDEADBEEF granted, then d_we=0 read of 0x0010 -> single d_rvalid with d_rdata=0xDEADBEEF, one cycle after the read grant; no rvalid for the write.
- Fairness: MAX_DATA_RUN=4, f_req and d_req held continuously -> grant pattern D,D,D,D,F repeating; run_cnt returns to 0 after each F.
- Latency tagging: RD_LAT=3, alternating fetch/data reads over 6 cycles -> rvalids appear 3 cycles after each grant, on the matching owner, in grant order; busy high from first grant until last rvalid.
- Reset mid-flight: RD_LAT=3, two reads granted, then RST_F=1 for 1 cycle -> no f_rvalid/d_rvalid in the following 4 cycles; busy=0 the cycle after reset.
